// File: rtl/filter_seq_ctrl_pkg.sv
// Shared definitions for the filter sequencing controller.
//   state_t        : FSM state encoding (also exported on the debug port)
//   COORD_W        : width of every x/y coordinate bus
//   calc_latency() : filter-enable cycles between a source pixel entering
//                    the row buffers and its filtered result appearing
package filter_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int COORD_W = 16;

  // Half a window of full lines plus half a window of pixels must be buffered
  // before the window is centred on pixel (0,0); PIPE adds datapath registers.
  function automatic int calc_latency(input int n, input int line_width, input int pipe);
    return (n / 2) * line_width + (n / 2) + pipe;
  endfunction

endpackage

// File: rtl/filter_seq_ctrl_raster_counter.sv
// Raster-order x/y counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to (0,0) (takes priority over en)
//   en       : advance one position in raster order
//   x, y     : current position
//   last     : current position is (LINE_WIDTH-1, ROW_NUMBER-1)
// x runs 0..LINE_WIDTH-1; on wrap y increments, and y wraps after ROW_NUMBER-1.
module filter_seq_ctrl_raster_counter
  import filter_seq_ctrl_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(LINE_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(ROW_NUMBER - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/filter_seq_ctrl.sv
// Sequencing controller for a windowed (NxN) image filter.
// Reads one frame in raster order, drives the row-buffer/filter clock enable,
// zero-pads after the last source pixel until every result has emerged, and
// tags each valid result with its coordinates and frame markers.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : request one frame pass (honoured only in IDLE)
//   in_valid          : source pixel available this cycle
//   rd_en             : pixel at (x_in,y_in) consumed this cycle
//   x_in, y_in        : read coordinates
//   filt_en           : clock enable for row buffers and filter
//   pad               : filter input is zero padding this cycle
//   out_valid         : filter result valid this cycle
//   x_out, y_out      : coordinates of the current result
//   sof, eol, eof     : first pixel / end of line / end of frame (with out_valid)
//   busy, done        : pass in progress / one-cycle completion pulse
//   dbg_state         : current FSM state encoding
//
// Handshake: the source offers a pixel with in_valid; it is taken in exactly
// the cycles where rd_en is high (rd_en never asserts without in_valid), and
// a stalled source freezes every counter. During drain the source is ignored.
module filter_seq_ctrl
  import filter_seq_ctrl_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int ROW_NUMBER = 480,
  parameter int N          = 3,
  parameter int PIPE       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               rd_en,
  output logic [COORD_W-1:0] x_in,
  output logic [COORD_W-1:0] y_in,
  output logic               filt_en,
  output logic               pad,
  output logic               out_valid,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int LATENCY = calc_latency(N, LINE_WIDTH, PIPE);
  localparam int TOTAL   = LINE_WIDTH * ROW_NUMBER;
  localparam int K_W     = $clog2(TOTAL + LATENCY + 1);

  localparam logic [K_W-1:0]     LAT_K  = K_W'(LATENCY);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(LINE_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROW_NUMBER - 1);

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d;

  logic reading;
  logic draining;
  logic clr;
  logic rd_last;

  // Counters restart at the start of every pass so a previous pass (or an
  // abort) leaves nothing behind.
  assign clr      = (state_q == ST_IDLE) && start;
  assign reading  = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign draining = (state_q == ST_DRAIN);

  assign rd_en     = reading && in_valid;
  assign filt_en   = reading ? in_valid : draining;
  assign pad       = draining;
  assign out_valid = filt_en && (k_q >= LAT_K);
  assign busy      = reading || draining;
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  assign sof = out_valid && (x_out == '0) && (y_out == '0);
  assign eol = out_valid && (x_out == X_LAST);
  assign eof = eol && (y_out == Y_LAST);

  filter_seq_ctrl_raster_counter #(
    .LINE_WIDTH (LINE_WIDTH),
    .ROW_NUMBER (ROW_NUMBER)
  ) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (rd_en),
    .x    (x_in),
    .y    (y_in),
    .last (rd_last)
  );

  // Result k-LATENCY is produced on the k-th enable, so the output counter
  // simply advances on every valid result.
  filter_seq_ctrl_raster_counter #(
    .LINE_WIDTH (LINE_WIDTH),
    .ROW_NUMBER (ROW_NUMBER)
  ) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (out_valid),
    .x    (x_out),
    .y    (y_out),
    .last ()
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (clr) begin
      k_d = '0;
    end else if (filt_en) begin
      k_d = k_q + 1'b1;
    end
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FILL;
      // Reading the last pixel wins over the fill boundary so a frame that
      // ends exactly as fill completes goes straight to drain.
      ST_FILL: begin
        if (rd_en && rd_last) begin
          state_d = ST_DRAIN;
        end else if (filt_en && (k_q == LAT_K - 1'b1)) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: if (rd_en && rd_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (out_valid && eof) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Bench for filter_seq_ctrl at LINE_WIDTH=8, ROW_NUMBER=4, N=3, PIPE=1.
// The reference model tracks a pass as "pixels read" and "enables given"
// counts and derives every output arithmetically from them.
module tb_filter_seq_ctrl;

  localparam int LW    = 8;
  localparam int RN    = 4;
  localparam int NW    = 3;
  localparam int PP    = 1;
  localparam int LAT   = (NW / 2) * LW + NW / 2 + PP;
  localparam int TOTAL = LW * RN;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  always #5 clk = ~clk;

  logic        rd_en, filt_en, pad, out_valid, sof, eol, eof, busy, done;
  logic [15:0] x_in, y_in, x_out, y_out;
  logic [2:0]  dbg_state;

  filter_seq_ctrl #(
    .LINE_WIDTH (LW),
    .ROW_NUMBER (RN),
    .N          (NW),
    .PIPE       (PP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .rd_en     (rd_en),
    .x_in      (x_in),
    .y_in      (y_in),
    .filt_en   (filt_en),
    .pad       (pad),
    .out_valid (out_valid),
    .x_out     (x_out),
    .y_out     (y_out),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // scoreboard counters
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  // reference model: 0 idle, 1 active (reading or draining), 3 done
  int m_mode, m_r, m_k, m_t;

  // per-pass observations of the DUT
  int first_rd, last_rd, first_pad, first_ov, last_ov, done_t, done_cnt, fe_cnt;
  int sof_t, eof_t, eol_cnt;

  task automatic clear_obs();
    first_rd = -1; last_rd = -1; first_pad = -1; first_ov = -1; last_ov = -1;
    done_t = -1; done_cnt = 0; fe_cnt = 0; sof_t = -1; eof_t = -1; eol_cnt = 0;
  endtask

  // driver: one clock cycle with given inputs, checked against the model
  task automatic step(input logic s, input logic v, input logic r);
    logic e_fe, e_rd, e_pad, e_ov, e_busy, e_done, e_sof, e_eol, e_eof;
    int o, e_xi, e_yi, e_xo, e_yo;
    @(negedge clk);
    start = s; in_valid = v; rst = r;
    #1;
    e_fe = 0; e_rd = 0; e_pad = 0; e_busy = 0; e_done = 0;
    if (m_mode == 1) begin
      e_busy = 1;
      if (m_r < TOTAL) begin
        e_fe = v; e_rd = v;
      end else begin
        e_fe = 1; e_pad = 1;
      end
    end else if (m_mode == 3) begin
      e_done = 1;
    end
    o     = ((m_k >= LAT) ? m_k - LAT : 0) % TOTAL;
    e_ov  = e_fe && (m_k >= LAT);
    e_xi  = (m_r % TOTAL) % LW;
    e_yi  = (m_r % TOTAL) / LW;
    e_xo  = o % LW;
    e_yo  = o / LW;
    e_sof = e_ov && (o == 0);
    e_eol = e_ov && (e_xo == LW - 1);
    e_eof = e_eol && (e_yo == RN - 1);

    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("filt_en", 32'(filt_en), 32'(e_fe));
    chk("pad", 32'(pad), 32'(e_pad));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("x_in", 32'(x_in), 32'(e_xi));
    chk("y_in", 32'(y_in), 32'(e_yi));
    chk("x_out", 32'(x_out), 32'(e_xo));
    chk("y_out", 32'(y_out), 32'(e_yo));
    chk("sof", 32'(sof), 32'(e_sof));
    chk("eol", 32'(eol), 32'(e_eol));
    chk("eof", 32'(eof), 32'(e_eof));

    if (m_mode != 0) begin
      if (rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = m_t;
        last_rd = m_t;
      end
      if (pad === 1'b1 && first_pad < 0) first_pad = m_t;
      if (out_valid === 1'b1) begin
        if (first_ov < 0) first_ov = m_t;
        last_ov = m_t;
      end
      if (filt_en === 1'b1) fe_cnt++;
      if (sof === 1'b1) sof_t = m_t;
      if (eof === 1'b1) eof_t = m_t;
      if (eol === 1'b1) eol_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_t = m_t;
      end
    end

    // model advance over the coming edge
    if (r) begin
      m_mode = 0; m_r = 0; m_k = 0;
    end else begin
      case (m_mode)
        0: if (s) begin m_mode = 1; m_r = 0; m_k = 0; m_t = 0; end
        1: begin
          if (e_fe) m_k++;
          if (e_rd) m_r++;
          if (e_ov && e_eof) m_mode = 3;
          m_t++;
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  // mode 0 plain, 1 stall at k=5, 2 start during stream, 3 reset at t=20,
  // 4 in_valid low in drain, 5 random
  task automatic run_pass(input int mode);
    int n;
    logic s, v, r;
    clear_obs();
    step(1'b1, 1'b1, 1'b0);
    n = 0;
    while (m_mode != 0 && n < 300) begin
      s = 0; v = 1; r = 0;
      case (mode)
        1: v = !(m_t >= 5 && m_t <= 7);
        2: s = (m_t == 20);
        3: r = (m_t == 20);
        4: v = (m_r < TOTAL);
        5: begin
          v = ($urandom_range(0, 3) != 0);
          s = ($urandom_range(0, 7) == 0);
        end
        default: ;
      endcase
      step(s, v, r);
      n++;
    end
    if (n >= 300) chk("pass_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    m_mode = 0; m_r = 0; m_k = 0; m_t = 0;
    clear_obs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    // reset state, then idle with start absent
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // constant in_valid: reference timing and markers
    run_pass(0);
    chk("t0_first_rd", first_rd, 0);
    chk("t0_last_rd", last_rd, 31);
    chk("t0_first_pad", first_pad, 32);
    chk("t0_first_ov", first_ov, 10);
    chk("t0_last_ov", last_ov, 41);
    chk("t0_done_t", done_t, 42);
    chk("t0_done_cnt", done_cnt, 1);
    chk("t0_fe_cnt", fe_cnt, TOTAL + LAT);
    chk("t0_sof_t", sof_t, 10);
    chk("t0_eof_t", eof_t, 41);
    chk("t0_eol_cnt", eol_cnt, RN);
    step(1'b0, 1'b1, 1'b0);

    // three-cycle stall at k=5
    run_pass(1);
    chk("t1_first_ov", first_ov, 13);
    chk("t1_done_t", done_t, 45);
    chk("t1_fe_cnt", fe_cnt, TOTAL + LAT);

    // start during stream is ignored
    run_pass(2);
    chk("t2_fe_cnt", fe_cnt, 42);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_t", done_t, 42);

    // abort at t=20, idle afterwards, then a fresh pass reproduces timing
    run_pass(3);
    chk("t3_done_cnt", done_cnt, 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_pass(0);
    chk("t3_first_ov", first_ov, 10);
    chk("t3_first_pad", first_pad, 32);
    chk("t3_done_t", done_t, 42);

    // source idle during drain
    run_pass(4);
    chk("t4_done_t", done_t, 42);
    chk("t4_fe_cnt", fe_cnt, 42);

    // random source stalls and spurious starts
    for (int p = 0; p < 6; p++) begin
      run_pass(5);
      chk("t5_fe_cnt", fe_cnt, TOTAL + LAT);
      chk("t5_done_cnt", done_cnt, 1);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
